// File: rtl/triangle_wave_gen_pkg.sv
// Shared constants for the triangle wave generator.
// Direction encoding used by the counter state flop.
package triangle_wave_gen_pkg;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/adder_n.sv
// N-bit ripple adder primitive with carry in/out.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

// File: rtl/comparator_eq.sv
// N-bit equality comparator primitive.
module comparator_eq #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out
);
  assign out = (a == b);
endmodule

// File: rtl/mux2.sv
// W-bit two-input multiplexer primitive; sel=0 picks a, sel=1 picks b.
module mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] out
);
  assign out = sel ? b : a;
endmodule

// File: rtl/triangle_wave_gen.sv
// Triangle waveform counter: ramps 0 -> 2^N-1 -> 0 on enabled cycles.
// Handshake: none; ena=1 at a posedge advances one step, ena=0 holds state.
module triangle_wave_gen
  import triangle_wave_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  output logic [N-1:0] out,
  output logic         dir
);
  localparam logic [N-1:0] ALL_ONES  = {N{1'b1}};
  localparam logic [N-1:0] ALL_ZEROS = {N{1'b0}};
  localparam logic [N-1:0] STEP_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_out;
  logic         r_dir;
  logic [N-1:0] w_thresh;
  logic         w_at_end;
  logic         w_next_dir;
  logic [N-1:0] w_step;
  logic [N-1:0] w_sum;
  logic         w_unused_carry;

  mux2 #(.W(N)) u_thresh_mux (
    .a   (ALL_ONES),
    .b   (ALL_ZEROS),
    .sel (r_dir),
    .out (w_thresh)
  );

  comparator_eq #(.N(N)) u_end_cmp (
    .a   (r_out),
    .b   (w_thresh),
    .out (w_at_end)
  );

  // At an endpoint the direction flips and the reversed step is applied on the same edge.
  assign w_next_dir = r_dir ^ w_at_end;

  mux2 #(.W(N)) u_step_mux (
    .a   (STEP_ONE),
    .b   (ALL_ONES),
    .sel (w_next_dir),
    .out (w_step)
  );

  adder_n #(.N(N)) u_step_add (
    .a     (r_out),
    .b     (w_step),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_unused_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out <= ALL_ZEROS;
      r_dir <= DIR_UP;
    end else if (ena) begin
      r_out <= w_sum;
      r_dir <= w_next_dir;
    end
  end

  assign out = r_out;
  assign dir = r_dir;
endmodule

// File: tb/tb_triangle_wave_gen.sv
// Bench for triangle_wave_gen at N=2, 3 and 8 sharing one stimulus stream.
module tb_triangle_wave_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [1:0] out2;
  logic [2:0] out3;
  logic [7:0] out8;
  logic       dir2, dir3, dir8;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp2_q[$];
  logic [3:0] exp3_q[$];
  logic [8:0] exp8_q[$];

  int   m2o = 0, m3o = 0, m8o = 0;
  logic m2d = 1'b0, m3d = 1'b0, m8d = 1'b0;
  int   prev3 = 0;
  bit   have_prev3 = 1'b0;

  int t2o[12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
  int t2d[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  triangle_wave_gen #(.N(2)) u_dut2 (.clk(clk), .rst(rst), .ena(ena), .out(out2), .dir(dir2));
  triangle_wave_gen #(.N(3)) u_dut3 (.clk(clk), .rst(rst), .ena(ena), .out(out3), .dir(dir3));
  triangle_wave_gen #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .ena(ena), .out(out8), .dir(dir8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int maxv, input logic r, input logic e,
                            inout int o, inout logic d);
    if (!r) begin
      o = 0;
      d = 1'b0;
    end else if (e) begin
      if (!d) begin
        if (o == maxv) begin d = 1'b1; o = maxv - 1; end
        else o = o + 1;
      end else begin
        if (o == 0) begin d = 1'b0; o = 1; end
        else o = o - 1;
      end
    end
  endtask

  // Drive one cycle, queue the model's prediction, then compare after the edge.
  task automatic step(input logic r, input logic e);
    logic [2:0] e2;
    logic [3:0] e3;
    logic [8:0] e8;
    int delta;
    @(negedge clk);
    rst = r;
    ena = e;
    model_step(3,   r, e, m2o, m2d);
    model_step(7,   r, e, m3o, m3d);
    model_step(255, r, e, m8o, m8d);
    exp2_q.push_back({m2d, 2'(m2o)});
    exp3_q.push_back({m3d, 3'(m3o)});
    exp8_q.push_back({m8d, 8'(m8o)});
    @(posedge clk);
    #1;
    e2 = exp2_q.pop_front();
    e3 = exp3_q.pop_front();
    e8 = exp8_q.pop_front();
    chk("model_n2", {29'd0, dir2, out2}, {29'd0, e2});
    chk("model_n3", {28'd0, dir3, out3}, {28'd0, e3});
    chk("model_n8", {23'd0, dir8, out8}, {23'd0, e8});
    if (r && have_prev3) begin
      delta = int'(out3) - prev3;
      chk("n3_delta_le1", {31'd0, (delta >= -1 && delta <= 1)}, 32'd1);
    end
    if (!r) have_prev3 = 1'b1;
    prev3 = int'(out3);
  endtask

  task automatic expect8(input string tag, input int o, input logic d);
    chk({tag, "_out"}, {24'd0, out8}, o);
    chk({tag, "_dir"}, {31'd0, dir8}, {31'd0, d});
  endtask

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_out2", {30'd0, out2}, 32'd0);
    chk("rst_dir2", {31'd0, dir2}, 32'd0);
    chk("rst_out3", {29'd0, out3}, 32'd0);
    expect8("rst8", 0, 1'b0);

    for (int k = 1; k <= 511; k++) begin
      step(1'b1, 1'b1);
      if (k <= 12) begin
        chk("period_n2_out", {30'd0, out2}, t2o[k-1]);
        chk("period_n2_dir", {31'd0, dir2}, t2d[k-1]);
      end
      if (k <= 3)   expect8("ramp8", k, 1'b0);
      if (k == 255) expect8("peak8", 255, 1'b0);
      if (k == 256) expect8("turn_down8", 254, 1'b1);
      if (k == 510) expect8("trough8", 0, 1'b1);
      if (k == 511) expect8("turn_up8", 1, 1'b0);
    end

    step(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
    expect8("gate_start", 5, 1'b0);
    step(1'b1, 1'b1); expect8("gate_en1", 6, 1'b0);
    step(1'b1, 1'b0); expect8("gate_hold1", 6, 1'b0);
    step(1'b1, 1'b0); expect8("gate_hold2", 6, 1'b0);
    step(1'b1, 1'b1); expect8("gate_en2", 7, 1'b0);

    for (int k = 0; k < 248; k++) step(1'b1, 1'b1);
    expect8("peak_reach", 255, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      expect8("peak_hold", 255, 1'b0);
    end
    step(1'b1, 1'b1); expect8("peak_resume", 254, 1'b1);

    for (int k = 0; k < 154; k++) step(1'b1, 1'b1);
    expect8("down100", 100, 1'b1);
    step(1'b0, 1'b1); expect8("midramp_rst", 0, 1'b0);
    step(1'b1, 1'b1); expect8("after_rst", 1, 1'b0);

    for (int k = 0; k < 10000; k++) begin
      step(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
